// File: rtl/corescore_rx_pkg.sv
// Shared types and defaults for the JTAG-UART receive bridge.
package corescore_rx_pkg;

  localparam logic [7:0]  DEFAULT_EOL_CHAR    = 8'h0A;
  localparam int unsigned DEFAULT_IDLE_CYCLES = 1024;

  typedef struct packed {
    logic       last;
    logic [7:0] dat;
  } rx_entry_t;

endpackage

// File: rtl/corescore_rx_fifo.sv
// Synchronous show-ahead FIFO of rx_entry_t; head entry reads as zero while empty.
module corescore_rx_fifo
  import corescore_rx_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                push,
  input  rx_entry_t           wdata,
  input  logic                pop,
  output rx_entry_t           rdata,
  output logic                full,
  output logic                empty,
  output logic [DEPTH_LOG2:0] free
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  rx_entry_t             mem [DEPTH];
  logic [DEPTH_LOG2:0]   wptr_q, rptr_q;
  logic [DEPTH_LOG2:0]   count;
  logic                  wr_en, rd_en;

  assign count = wptr_q - rptr_q;
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[DEPTH_LOG2] != rptr_q[DEPTH_LOG2]) &&
                 (wptr_q[DEPTH_LOG2-1:0] == rptr_q[DEPTH_LOG2-1:0]);
  assign free  = (DEPTH_LOG2 + 1)'(DEPTH) - count;

  // A pop frees the head slot in the same cycle, so a push into a full FIFO is legal then.
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;

  assign rdata = empty ? '0 : mem[rptr_q[DEPTH_LOG2-1:0]];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wptr_q[DEPTH_LOG2-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (wr_en) wptr_q <= wptr_q + 1'b1;
      if (rd_en) rptr_q <= rptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/corescore_jtag_rx.sv
// JTAG-UART host-to-device bytes to AXI-stream bytes, framed by EOL_CHAR.
// Define CORESCORE_RX_TIMEOUT_EN to also close a packet after IDLE_CYCLES idle clocks.
module corescore_jtag_rx
  import corescore_rx_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2  = 4,
  parameter logic [7:0]  EOL_CHAR    = DEFAULT_EOL_CHAR,
  parameter int unsigned IDLE_CYCLES = DEFAULT_IDLE_CYCLES
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic [7:0] i_rx_dat,
  input  logic       i_rx_ena,
  output logic       o_rx_dav,
  output logic [7:0] o_tdata,
  output logic       o_tlast,
  output logic       o_tvalid,
  input  logic       i_tready,
  output logic       o_overflow
);

  logic       pend_vld_q, pend_eol_q;
  logic [7:0] pend_dat_q;
  logic       pend_clear;

  logic       push, pop, push_ok;
  rx_entry_t  push_entry, head;
  logic       fifo_full, fifo_empty;
  logic [DEPTH_LOG2:0]   fifo_free;
  logic [DEPTH_LOG2+1:0] free_next;

  logic       dav_q, overflow_q;
  logic       timeout_fire;

`ifdef CORESCORE_RX_TIMEOUT_EN
  localparam int unsigned CNT_W = (IDLE_CYCLES > 2) ? $clog2(IDLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_FIRE = CNT_W'(IDLE_CYCLES - 1);

  logic [CNT_W-1:0] idle_cnt_q;
  logic             idle_armed;

  assign idle_armed   = pend_vld_q && !pend_eol_q;
  // A byte arriving in the firing cycle wins: the pending byte goes out with last=0.
  assign timeout_fire = idle_armed && !i_rx_ena && (idle_cnt_q == CNT_FIRE);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      idle_cnt_q <= '0;
    end else if (i_rx_ena || !idle_armed) begin
      idle_cnt_q <= '0;
    end else if (idle_cnt_q != CNT_FIRE) begin
      idle_cnt_q <= idle_cnt_q + 1'b1;
    end
  end
`else
  logic unused_idle_cycles;
  assign unused_idle_cycles = ^IDLE_CYCLES;
  assign timeout_fire       = 1'b0;
`endif

  // Push arbitration: at most one FIFO write per cycle, always of the pending byte.
  always_comb begin
    push       = 1'b0;
    push_entry = '0;
    pend_clear = 1'b0;
    if (pend_vld_q && pend_eol_q) begin
      push       = 1'b1;
      push_entry = '{last: 1'b1, dat: pend_dat_q};
      pend_clear = 1'b1;
    end else if (i_rx_ena && pend_vld_q) begin
      push       = 1'b1;
      push_entry = '{last: 1'b0, dat: pend_dat_q};
    end else if (timeout_fire && pend_vld_q) begin
      push       = 1'b1;
      push_entry = '{last: 1'b1, dat: pend_dat_q};
      pend_clear = 1'b1;
    end
  end

  assign pop     = !fifo_empty && i_tready;
  assign push_ok = push && (!fifo_full || pop);

  always_comb begin
    free_next = {1'b0, fifo_free};
    if (push_ok) free_next = free_next - 1'b1;
    if (pop)     free_next = free_next + 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      pend_vld_q <= 1'b0;
      pend_eol_q <= 1'b0;
      pend_dat_q <= '0;
    end else if (i_rx_ena) begin
      pend_vld_q <= 1'b1;
      pend_eol_q <= (i_rx_dat == EOL_CHAR);
      pend_dat_q <= i_rx_dat;
    end else if (pend_clear) begin
      pend_vld_q <= 1'b0;
    end
  end

  // Two free slots keep room for one byte already in flight once dav drops.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      dav_q      <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      dav_q <= (free_next >= (DEPTH_LOG2 + 2)'(2));
      if (push && !push_ok) overflow_q <= 1'b1;
    end
  end

  corescore_rx_fifo #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_fifo (
    .clk   (i_clk),
    .rst_n (i_rstn),
    .push  (push),
    .wdata (push_entry),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .free  (fifo_free)
  );

  assign o_tvalid   = !fifo_empty;
  assign o_tdata    = head.dat;
  assign o_tlast    = head.last;
  assign o_rx_dav   = dav_q;
  assign o_overflow = overflow_q;

endmodule

// File: tb/tb_corescore_jtag_rx.sv
// Directed bench for corescore_jtag_rx; adapts to CORESCORE_RX_TIMEOUT_EN.
module tb_corescore_jtag_rx;

  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] rx_dat;
  logic       rx_ena;
  logic       rx_dav;
  logic [7:0] tdata;
  logic       tlast;
  logic       tvalid;
  logic       tready;
  logic       overflow;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  corescore_jtag_rx #(
    .DEPTH_LOG2  (2),
    .EOL_CHAR    (8'h0A),
    .IDLE_CYCLES (16)
  ) dut (
    .i_clk      (clk),
    .i_rstn     (rstn),
    .i_rx_dat   (rx_dat),
    .i_rx_ena   (rx_ena),
    .o_rx_dav   (rx_dav),
    .o_tdata    (tdata),
    .o_tlast    (tlast),
    .o_tvalid   (tvalid),
    .i_tready   (tready),
    .o_overflow (overflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_beat(input string tag, input logic [7:0] dat, input logic last);
    check({tag, ".tvalid"}, {31'd0, tvalid}, 32'd1);
    check({tag, ".tdata"},  {24'd0, tdata},  {24'd0, dat});
    check({tag, ".tlast"},  {31'd0, tlast},  {31'd0, last});
  endtask

  // Inputs change on the falling edge; outputs are read there too.
  task automatic step;
    @(negedge clk);
  endtask

  task automatic drive(input logic [7:0] b);
    rx_dat = b;
    rx_ena = 1'b1;
    step();
  endtask

  initial begin
    rstn   = 1'b0;
    rx_dat = 8'h00;
    rx_ena = 1'b0;
    tready = 1'b1;

    // Reset state
    repeat (2) step();
    check("rst.dav",      {31'd0, rx_dav},   32'd0);
    check("rst.tvalid",   {31'd0, tvalid},   32'd0);
    check("rst.tdata",    {24'd0, tdata},    32'd0);
    check("rst.tlast",    {31'd0, tlast},    32'd0);
    check("rst.overflow", {31'd0, overflow}, 32'd0);
    rstn = 1'b1;
    #1 check("rel.dav_before_edge", {31'd0, rx_dav}, 32'd0);
    step();
    check("rel.dav_after_edge", {31'd0, rx_dav}, 32'd1);

    // "ab\n" back to back
    drive(8'h61);
    check("ab.first_pending", {31'd0, tvalid}, 32'd0);
    drive(8'h62);
    check_beat("ab.a", 8'h61, 1'b0);
    drive(8'h0A);
    check_beat("ab.b", 8'h62, 1'b0);
    rx_ena = 1'b0;
    step();
    check_beat("ab.nl", 8'h0A, 1'b1);
    step();
    check("ab.drained", {31'd0, tvalid}, 32'd0);
    check("ab.overflow", {31'd0, overflow}, 32'd0);

`ifdef CORESCORE_RX_TIMEOUT_EN
    // Lone byte closes exactly 16 cycles after its ena edge
    drive(8'h41);
    rx_ena = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      step();
      check("to.early", {31'd0, tvalid}, 32'd0);
    end
    step();
    check_beat("to.fire", 8'h41, 1'b1);
    step();
    check("to.drained", {31'd0, tvalid}, 32'd0);

    // A byte on the firing cycle beats the timeout
    drive(8'h42);
    rx_ena = 1'b0;
    repeat (15) step();
    check("tc.quiet", {31'd0, tvalid}, 32'd0);
    drive(8'h43);
    check_beat("tc.no_last", 8'h42, 1'b0);
    drive(8'h0A);
    check_beat("tc.next", 8'h43, 1'b0);
    rx_ena = 1'b0;
    step();
    check_beat("tc.eol", 8'h0A, 1'b1);
    step();
    check("tc.drained", {31'd0, tvalid}, 32'd0);
`else
    // Without the timeout a trailing byte waits for the next one
    drive(8'h41);
    rx_ena = 1'b0;
    repeat (100) step();
    check("nto.held", {31'd0, tvalid}, 32'd0);
    drive(8'h0A);
    rx_ena = 1'b0;
    check_beat("nto.a", 8'h41, 1'b0);
    step();
    check_beat("nto.eol", 8'h0A, 1'b1);
    step();
    check("nto.drained", {31'd0, tvalid}, 32'd0);
`endif

    // Backpressure with a 4-entry FIFO and the sink stalled
    tready = 1'b0;
    drive(8'h30);
    check("bp.dav0", {31'd0, rx_dav}, 32'd1);
    drive(8'h31);
    drive(8'h32);
    check("bp.dav2", {31'd0, rx_dav}, 32'd1);
    drive(8'h33);
    check("bp.dav_low", {31'd0, rx_dav}, 32'd0);
    check("bp.no_ovf", {31'd0, overflow}, 32'd0);
    drive(8'h34);
    check("bp.last_slot_ovf", {31'd0, overflow}, 32'd0);
    check("bp.stable", {24'd0, tdata}, 32'h30);
    drive(8'h35);
    rx_ena = 1'b0;
    check("bp.ovf", {31'd0, overflow}, 32'd1);
    check_beat("bp.head", 8'h30, 1'b0);
    tready = 1'b1;
    step();
    check_beat("bp.e1", 8'h31, 1'b0);
    step();
    check_beat("bp.e2", 8'h32, 1'b0);
    step();
    check_beat("bp.e3", 8'h33, 1'b0);
    step();
    check("bp.only4", {31'd0, tvalid}, 32'd0);
    check("bp.dav_back", {31'd0, rx_dav}, 32'd1);
    check("bp.ovf_sticky", {31'd0, overflow}, 32'd1);

    // Asynchronous reset with three entries buffered (0x35 was pending)
    tready = 1'b0;
    drive(8'h61);
    drive(8'h62);
    drive(8'h63);
    rx_ena = 1'b0;
    check_beat("mr.buffered", 8'h35, 1'b0);
    #2 rstn = 1'b0;
    #1;
    check("mr.tvalid", {31'd0, tvalid},   32'd0);
    check("mr.tdata",  {24'd0, tdata},    32'd0);
    check("mr.dav",    {31'd0, rx_dav},   32'd0);
    check("mr.ovf",    {31'd0, overflow}, 32'd0);
    step();
    rstn = 1'b1;
    step();
    check("mr.dav_after", {31'd0, rx_dav}, 32'd1);
    check("mr.empty", {31'd0, tvalid}, 32'd0);
    tready = 1'b1;
    drive(8'h0A);
    rx_ena = 1'b0;
    check("mr.no_stale", {31'd0, tvalid}, 32'd0);
    step();
    check_beat("mr.eol", 8'h0A, 1'b1);
    step();
    check("mr.drained", {31'd0, tvalid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
